// File: rtl/npu_pkg.sv
// Shared definitions for the convolution engine: host address map, CTRL bits
// and sequencer states.
package npu_pkg;
  localparam logic [2:0] SEL_CTRL   = 3'd0;
  localparam logic [2:0] SEL_IMG    = 3'd1;
  localparam logic [2:0] SEL_WGT    = 3'd2;
  localparam logic [2:0] SEL_BIAS   = 3'd3;
  localparam logic [2:0] SEL_RESULT = 3'd4;
  localparam logic [2:0] SEL_STATUS = 3'd5;

  localparam int CTRL_START    = 0;
  localparam int CTRL_SOFT_CLR = 1;
  localparam int CTRL_RELU_EN  = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB, S_FIN} state_e;
endpackage

// File: rtl/npu_mac_lane.sv
// One MAC lane: accumulates signed weight times unsigned pixel on top of a
// preloaded bias.
module npu_mac_lane #(
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] bias,
  input  logic        [7:0]       pix,
  input  logic signed [7:0]       wgt,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] acc_q;

  // Pixel is zero-extended so the product stays signed in 17 bits.
  assign prod = 17'(wgt) * 17'($signed({1'b0, pix}));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)   acc_q <= '0;
    else if (load) acc_q <= bias;
    else if (en)   acc_q <= acc_q + {{(ACC_W-17){prod[16]}}, prod};
  end

  assign acc = acc_q;
endmodule

// File: rtl/npu_conv_engine.sv
// Self-sequencing 2-D convolution engine behind a single memory-mapped port;
// NUM_PE lanes compute adjacent output columns, one kernel tap per cycle.
module npu_conv_engine
  import npu_pkg::*;
#(
  parameter int IMG_H  = 16,
  parameter int IMG_W  = 15,
  parameter int K      = 3,
  parameter int NUM_PE = 4,
  parameter int ACC_W  = 24
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        ena,
  input  logic        wea,
  input  logic [15:0] addra,
  input  logic [31:0] dina,
  output logic [31:0] douta
);
  localparam int OUT_H  = IMG_H - K + 1;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int IMG_N  = IMG_H * IMG_W;
  localparam int WGT_N  = K * K;
  localparam int OUT_N  = OUT_H * OUT_W;
  localparam int IMG_AW = $clog2(IMG_N);
  localparam int WGT_AW = $clog2(WGT_N);
  localparam int RES_AW = $clog2(OUT_N);

  logic [2:0]  sel;
  logic [11:0] idx;
  logic        unused_addr;
  assign sel         = addra[14:12];
  assign idx         = addra[11:0];
  assign unused_addr = addra[15];

  logic        [7:0]       img_q [IMG_N];
  logic signed [7:0]       wgt_q [WGT_N];
  logic signed [ACC_W-1:0] bias_q;
  logic signed [ACC_W-1:0] res_q [OUT_N];

  state_e      state_q, state_d;
  logic [7:0]  row_q, col_q, ti_q, tj_q;
  logic        done_q, err_q, relu_q;
  logic [31:0] douta_q, rd_d;
  logic        busy, lane_load, lane_en, wb_en;

  logic wr, ctrl_wr, start, soft_clr, buf_wr, img_we, wgt_we, bias_we;
  assign wr       = ena & wea;
  assign ctrl_wr  = wr && (sel == SEL_CTRL) && (idx == 12'd0);
  assign start    = ctrl_wr & dina[CTRL_START];
  assign soft_clr = ctrl_wr & dina[CTRL_SOFT_CLR];
  assign buf_wr   = wr && ((sel == SEL_IMG) || (sel == SEL_WGT) || (sel == SEL_BIAS));
  assign img_we   = wr && (sel == SEL_IMG)  && !busy;
  assign wgt_we   = wr && (sel == SEL_WGT)  && !busy;
  assign bias_we  = wr && (sel == SEL_BIAS) && !busy && (idx == 12'd0);

  logic last_tap, row_end, last_row;
  assign last_tap = (ti_q == 8'(K-1)) && (tj_q == 8'(K-1));
  assign row_end  = (col_q + 8'(NUM_PE)) >= 8'(OUT_W);
  assign last_row = (row_q == 8'(OUT_H-1));

  function automatic logic signed [ACC_W-1:0] wb_value(input logic signed [ACC_W-1:0] a,
                                                        input logic relu);
    return (relu && (a < 0)) ? '0 : a;
  endfunction

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_tap) state_d = S_WB;
      S_WB:    state_d = (row_end && last_row) ? S_FIN : S_RUN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (soft_clr) state_d = S_IDLE;
  end

  // WB reloads bias so the next group starts clean while results are written.
  always_comb begin
    busy      = (state_q == S_RUN) || (state_q == S_WB);
    lane_load = ((state_q == S_IDLE) && start && !soft_clr) || (state_q == S_WB);
    lane_en   = (state_q == S_RUN);
    wb_en     = (state_q == S_WB);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0; col_q <= '0; ti_q <= '0; tj_q <= '0;
      done_q <= 1'b0; err_q <= 1'b0; relu_q <= 1'b0;
    end else if (soft_clr) begin
      row_q <= '0; col_q <= '0; ti_q <= '0; tj_q <= '0;
      done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      if (ctrl_wr) relu_q <= dina[CTRL_RELU_EN];
      if (buf_wr && busy) err_q <= 1'b1;
      case (state_q)
        S_IDLE: if (start) begin
          row_q <= '0; col_q <= '0; ti_q <= '0; tj_q <= '0;
          done_q <= 1'b0;
        end
        S_RUN: if (tj_q == 8'(K-1)) begin
          tj_q <= '0;
          ti_q <= last_tap ? 8'd0 : ti_q + 8'd1;
        end else begin
          tj_q <= tj_q + 8'd1;
        end
        S_WB: if (row_end) begin
          col_q <= '0;
          row_q <= row_q + 8'd1;
        end else begin
          col_q <= col_q + 8'(NUM_PE);
        end
        S_FIN:   done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  logic        [WGT_AW-1:0] widx;
  logic        [7:0]        pix      [NUM_PE];
  logic        [RES_AW-1:0] res_idx  [NUM_PE];
  logic signed [ACC_W-1:0]  lane_acc [NUM_PE];
  logic        [NUM_PE-1:0] lane_ok;
  assign widx = WGT_AW'(ti_q * 8'(K) + tj_q);

  for (genvar l = 0; l < NUM_PE; l++) begin : g_lane
    logic [7:0]        pc;
    logic [IMG_AW-1:0] pidx;
    assign pc   = col_q + tj_q + 8'(l);
    assign pidx = IMG_AW'(({8'd0, row_q} + {8'd0, ti_q}) * 16'(IMG_W) + {8'd0, pc});
    // Lanes past the last output column may reach beyond the row; feed them zero.
    assign pix[l]     = (pc < 8'(IMG_W)) ? img_q[pidx] : 8'd0;
    assign lane_ok[l] = (col_q + 8'(l)) < 8'(OUT_W);
    assign res_idx[l] = RES_AW'({8'd0, row_q} * 16'(OUT_W) + {8'd0, col_q} + 16'(l));

    npu_mac_lane #(.ACC_W(ACC_W)) u_lane (
      .clk(clk), .rst_ni(rst_ni), .load(lane_load), .en(lane_en),
      .bias(bias_q), .pix(pix[l]), .wgt(wgt_q[widx]), .acc(lane_acc[l])
    );
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < IMG_N; p++)
      if (img_we && (idx == 12'(p/4))) img_q[p] <= dina[(p%4)*8 +: 8];
    for (int t = 0; t < WGT_N; t++)
      if (wgt_we && (idx == 12'(t/4))) wgt_q[t] <= dina[(t%4)*8 +: 8];
    if (bias_we) bias_q <= dina[ACC_W-1:0];
    for (int l = 0; l < NUM_PE; l++)
      if (wb_en && lane_ok[l]) res_q[res_idx[l]] <= wb_value(lane_acc[l], relu_q);
  end

  always_comb begin
    rd_d = '0;
    case (sel)
      SEL_IMG:
        for (int p = 0; p < IMG_N; p++)
          if (idx == 12'(p/4)) rd_d[(p%4)*8 +: 8] = img_q[p];
      SEL_WGT:
        for (int t = 0; t < WGT_N; t++)
          if (idx == 12'(t/4)) rd_d[(t%4)*8 +: 8] = wgt_q[t];
      SEL_BIAS:   if (idx == 12'd0) rd_d = 32'(bias_q);
      SEL_RESULT: if (idx < 12'(OUT_N)) rd_d = 32'(res_q[idx[RES_AW-1:0]]);
      SEL_STATUS: if (idx == 12'd0) rd_d = {28'd0, err_q, relu_q, done_q, busy};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)          douta_q <= '0;
    else if (ena && !wea) douta_q <= rd_d;
  end

  assign douta = douta_q;
endmodule

// File: tb/tb_npu_conv_engine.sv
// Directed bench for the convolution engine: host-port loads, runs, latency and
// result checks with hand-computed values.
module tb_npu_conv_engine;
  import npu_pkg::*;

  localparam int OUT_H = 14;
  localparam int OUT_W = 13;
  localparam int OUT_N = OUT_H * OUT_W;
  localparam int LAT   = 561;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        ena = 1'b0;
  logic        wea = 1'b0;
  logic [15:0] addra = '0;
  logic [31:0] dina = '0;
  logic [31:0] douta;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  npu_conv_engine dut (
    .clk(clk), .rst_ni(rst_ni), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .douta(douta)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] s, input logic [11:0] i, input logic [31:0] d);
    @(negedge clk);
    ena = 1'b1; wea = 1'b1; addra = {1'b0, s, i}; dina = d;
    @(posedge clk); #1;
    ena = 1'b0; wea = 1'b0;
  endtask

  task automatic rd(input logic [2:0] s, input logic [11:0] i, output logic [31:0] d);
    @(negedge clk);
    ena = 1'b1; wea = 1'b0; addra = {1'b0, s, i};
    @(posedge clk); #1;
    d = douta;
    ena = 1'b0;
  endtask

  task automatic fill_img(input logic [7:0] v);
    for (int w = 0; w < 60; w++) wr(SEL_IMG, 12'(w), {4{v}});
  endtask

  task automatic fill_wgt(input logic [7:0] v);
    for (int w = 0; w < 3; w++) wr(SEL_WGT, 12'(w), {4{v}});
  endtask

  // Polls STATUS every cycle; latency is counted from the START write edge.
  task automatic wait_done(input int t0, input string tag, output logic [31:0] st);
    int lat;
    lat = -1;
    st = '0;
    for (int n = 0; n < 2000; n++) begin
      rd(SEL_STATUS, 12'd0, st);
      if (st[1]) begin
        lat = cyc - t0 - 1;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(LAT));
  endtask

  task automatic run(input logic relu, input string tag);
    int t0;
    logic [31:0] st;
    wr(SEL_CTRL, 12'd0, {29'd0, relu, 1'b0, 1'b1});
    t0 = cyc;
    rd(SEL_STATUS, 12'd0, st);
    chk({tag, " busy"}, st, {28'd0, 1'b0, relu, 1'b0, 1'b1});
    wait_done(t0, tag, st);
  endtask

  task automatic check_const(input logic [31:0] exp, input string tag);
    logic [31:0] d;
    for (int q = 0; q < OUT_N; q++) begin
      rd(SEL_RESULT, 12'(q), d);
      chk($sformatf("%s q=%0d", tag, q), d, exp);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] word;
    int t0;

    // 1: reset state and all-zero run
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_ni = 1'b1;
    #1 chk("reset douta", douta, 32'h0);
    rd(SEL_STATUS, 12'd0, d);
    chk("reset status", d, 32'h0);
    rd(SEL_CTRL, 12'd0, d);
    chk("ctrl reads 0", d, 32'h0);
    fill_img(8'h00);
    fill_wgt(8'h00);
    wr(SEL_BIAS, 12'd0, 32'h0);
    run(1'b0, "zero");
    check_const(32'h0, "zero");

    // 2: ones, then bias -4
    fill_img(8'h01);
    fill_wgt(8'h01);
    run(1'b0, "ones");
    check_const(32'd9, "ones");
    wr(SEL_BIAS, 12'd0, 32'hFFFF_FFFC);
    run(1'b0, "bias-4");
    check_const(32'd5, "bias-4");

    // 3: negative weights with and without ReLU, extreme magnitude
    wr(SEL_BIAS, 12'd0, 32'h0);
    fill_wgt(8'hFF);
    run(1'b0, "neg");
    check_const(32'hFFFF_FFF7, "neg");
    run(1'b1, "relu");
    check_const(32'h0, "relu");
    rd(SEL_STATUS, 12'd0, d);
    chk("relu status", d, 32'h6);
    fill_img(8'hFF);
    fill_wgt(8'h80);
    run(1'b0, "extreme");
    check_const(-32'sd293760, "extreme");

    // 4: img[r][c]=c with only the centre tap set
    for (int w = 0; w < 60; w++) begin
      word = '0;
      for (int b = 0; b < 4; b++) word[b*8 +: 8] = 8'(((4*w) + b) % 15);
      wr(SEL_IMG, 12'(w), word);
    end
    wr(SEL_WGT, 12'd0, 32'h0);
    wr(SEL_WGT, 12'd1, 32'h1);
    wr(SEL_WGT, 12'd2, 32'h0);
    run(1'b0, "shift");
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++) begin
        rd(SEL_RESULT, 12'(r*OUT_W + c), d);
        chk($sformatf("shift r=%0d c=%0d", r, c), d, 32'(c + 1));
      end
    rd(SEL_RESULT, 12'd182, d);
    chk("result idx 182", d, 32'h0);

    // 5: START and IMG write while busy, then SOFT_CLR mid-run
    fill_img(8'h01);
    fill_wgt(8'h01);
    wr(SEL_CTRL, 12'd0, 32'h1);
    t0 = cyc;
    repeat (10) rd(SEL_STATUS, 12'd0, d);
    chk("busy status", d, 32'h1);
    wr(SEL_CTRL, 12'd0, 32'h1);
    wr(SEL_IMG, 12'd0, 32'h0505_0505);
    rd(SEL_STATUS, 12'd0, d);
    chk("err while busy", d, 32'h9);
    wait_done(t0, "restart ignored", d);
    chk("done with err", d, 32'hA);
    rd(SEL_IMG, 12'd0, d);
    chk("image unchanged", d, 32'h0101_0101);
    check_const(32'd9, "after busy writes");
    wr(SEL_CTRL, 12'd0, 32'h2);
    rd(SEL_STATUS, 12'd0, d);
    chk("soft clr idle", d, 32'h0);
    wr(SEL_CTRL, 12'd0, 32'h1);
    repeat (99) @(posedge clk);
    #1 wr(SEL_CTRL, 12'd0, 32'h2);
    rd(SEL_STATUS, 12'd0, d);
    chk("soft clr mid-run", d, 32'h0);
    repeat (600) @(posedge clk);
    rd(SEL_STATUS, 12'd0, d);
    chk("no done after clr", d, 32'h0);

    // 6: async reset mid-run, then rerun
    wr(SEL_CTRL, 12'd0, 32'h1);
    repeat (50) @(posedge clk);
    rd(SEL_STATUS, 12'd0, d);
    chk("busy before rst", d, 32'h1);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1 chk("douta in rst", douta, 32'h0);
    @(negedge clk) rst_ni = 1'b1;
    rd(SEL_STATUS, 12'd0, d);
    chk("status after rst", d, 32'h0);
    run(1'b0, "rerun");
    check_const(32'd9, "rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
